// File: rtl/sum_2n_multi.sv
// sum_2n_multi: multi-channel block accumulator/decimator.
// Sums 2**n valid samples per signed channel. At each block end it publishes
// the full-precision sum and the mean (floor shift, or round-half-up with
// saturation when ROUND=1).
//   clk, rst   : clock, synchronous active-high reset
//   in         : CH packed signed R-bit samples, channel k = in[k*R +: R]
//   in_valid   : sample strobe
//   n_sel      : requested log2 block length (clamped to NMAX)
//   clr        : abort the running block; published outputs are held
//   out        : CH packed signed (R+NMAX)-bit block sums
//   mean       : CH packed signed R-bit block means
//   tick       : one-cycle pulse when out/mean update
//   n_act      : block length behind the published out/mean

// Per-channel datapath: running sum plus the mean and sum output registers.
module sum_2n_lane #(
  parameter int R     = 14,
  parameter int NMAX  = 10,
  parameter int NW    = 4,
  parameter int ROUND = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         din,
  input  logic                 acc_en,
  input  logic                 clr,
  input  logic                 blk_end,
  input  logic [NW-1:0]        n_eff,
  output logic [R+NMAX-1:0]    out,
  output logic [R-1:0]         mean
);
  localparam int SW = R + NMAX;
  // Representable mean range, held one bit wider than the sum so the rounding
  // add can never wrap.
  localparam logic signed [SW:0] MAXV = {{(SW-R+2){1'b0}}, {(R-1){1'b1}}};
  localparam logic signed [SW:0] MINV = {{(SW-R+2){1'b1}}, {(R-1){1'b0}}};

  logic signed [SW-1:0] sum, sum_nxt;
  logic signed [SW:0]   wide, rnd, shifted;
  logic [R-1:0]         mean_nxt;

  always_comb begin
    sum_nxt = sum + {{NMAX{din[R-1]}}, din};
    wide    = {sum_nxt[SW-1], sum_nxt};
    rnd     = '0;
    if (ROUND != 0 && n_eff != '0)
      rnd = (SW+1)'(1) << (n_eff - NW'(1));
    shifted  = (wide + rnd) >>> n_eff;
    mean_nxt = shifted[R-1:0];
    if (ROUND != 0) begin
      if (shifted > MAXV)      mean_nxt = MAXV[R-1:0];
      else if (shifted < MINV) mean_nxt = MINV[R-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      out  <= '0;
      mean <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (acc_en) begin
      if (blk_end) begin
        // Final sample is folded in directly; the next block starts from 0.
        sum  <= '0;
        out  <= sum_nxt;
        mean <= mean_nxt;
      end else begin
        sum <= sum_nxt;
      end
    end
  end
endmodule

module sum_2n_multi #(
  parameter int R     = 14,
  parameter int CH    = 2,
  parameter int NMAX  = 10,
  parameter int NW    = 4,
  parameter int ROUND = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH*R-1:0]        in,
  input  logic                   in_valid,
  input  logic [NW-1:0]          n_sel,
  input  logic                   clr,
  output logic [CH*(R+NMAX)-1:0] out,
  output logic [CH*R-1:0]        mean,
  output logic                   tick,
  output logic [NW-1:0]          n_act
);
  localparam int SW = R + NMAX;
  localparam int CW = NMAX + 1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc, blk_len;
  logic [NW-1:0] n_cur, n_cur_nxt, n_clamp, n_eff;
  logic          blk_end;

  // In IDLE the incoming sample opens a block, so n_sel applies immediately;
  // this is what lets n=0 end a block on its own first sample.
  always_comb begin
    n_clamp = (n_sel > NW'(NMAX)) ? NW'(NMAX) : n_sel;
    n_eff   = (state == IDLE) ? n_clamp : n_cur;
    cnt_inc = cnt + CW'(1);
    blk_len = CW'(1) << n_eff;
    blk_end = in_valid && !clr && (cnt_inc == blk_len);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_cur_nxt = n_cur;
    if (clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (in_valid) begin
      n_cur_nxt = n_eff;
      if (blk_end) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ACC;
        cnt_nxt   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      n_cur <= n_clamp;
      tick  <= 1'b0;
      n_act <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      n_cur <= n_cur_nxt;
      tick  <= blk_end;
      if (blk_end) n_act <= n_eff;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    sum_2n_lane #(.R(R), .NMAX(NMAX), .NW(NW), .ROUND(ROUND)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .din     (in[k*R +: R]),
      .acc_en  (in_valid),
      .clr     (clr),
      .blk_end (blk_end),
      .n_eff   (n_eff),
      .out     (out[k*SW +: SW]),
      .mean    (mean[k*R +: R])
    );
  end
endmodule
